// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs one imem req/ack at a time,
// hands words to decode over valid/ready. Optional macro: FETCH_CTRL_MISALIGN_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_inc,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        misalign_err
);
    typedef enum logic [2:0] {IDLE, FETCH, KILL, HOLD, HALT} state_t;

    state_t      state, state_d;
    logic [31:0] pc_q, pc_d, redir_q, redir_d, instr_d, instr_pc_d, tgt;
    logic        err_q, err_d, bad;

`ifdef FETCH_CTRL_MISALIGN_EN
    assign tgt = redirect_target;
    assign bad = redirect && (redirect_target[1:0] != 2'b00);
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^redirect_target[1:0];
    assign tgt = {redirect_target[31:2], 2'b00};
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            redir_q  <= RESET_PC;
            instr    <= '0;
            instr_pc <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            pc_q     <= pc_d;
            redir_q  <= redir_d;
            instr    <= instr_d;
            instr_pc <= instr_pc_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc_q;
        redir_d    = redir_q;
        instr_d    = instr;
        instr_pc_d = instr_pc;
        // A misaligned target is only "accepted" in states that honour redirects.
        err_d      = err_q | (bad && (state == FETCH || state == KILL || state == HOLD));
        case (state)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack && !redirect) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = HOLD;
                end else if (imem_ack) begin
                    pc_d    = tgt;
                    state_d = err_d ? HALT : FETCH;
                end else if (redirect) begin
                    redir_d = tgt;
                    state_d = KILL;
                end
            end
            KILL: begin
                if (redirect) redir_d = tgt;
                if (imem_ack) begin
                    pc_d    = redirect ? tgt : redir_q;
                    state_d = err_d ? HALT : FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = tgt;
                    state_d = err_d ? HALT : FETCH;
                end else if (dec_ready) begin
                    state_d = FETCH;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign imem_req     = (state == FETCH) || (state == KILL);
    assign imem_addr    = pc_q;
    assign instr_valid  = (state == HOLD);
    assign instr_pc_inc = instr_pc + 32'd4;
    assign misalign_err = err_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver pushes expected requests/transfers,
// a negedge monitor pops and compares; a responder process models imem latency.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, instr_valid, misalign_err;
    logic [31:0] imem_addr, instr, instr_pc, instr_pc_inc;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dec_ready, redirect;
    logic [31:0] redirect_target;

    int checks = 0, fails = 0, n_xfer = 0, ack_delay = 0, cnt = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] inc;
    } xfer_t;
    logic [31:0] exp_addr[$];
    xfer_t       exp_x[$];
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

`ifdef FETCH_CTRL_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_pc_inc(instr_pc_inc), .dec_ready(dec_ready),
        .redirect(redirect), .redirect_target(redirect_target),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_x(input logic [31:0] pc);
        xfer_t x;
        x.instr = mem(pc);
        x.pc    = pc;
        x.inc   = pc + 32'd4;
        exp_x.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_until(input int n);
        for (int i = 0; i < 200 && n_xfer < n; i++) step();
        chk("xfer_count", n_xfer, n);
        dec_ready = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !instr_valid; i++) step();
        chk("wait_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    // Memory model: ack after ack_delay extra cycles of a held request.
    always begin
        @(posedge clk);
        #1;
        if (rst || !imem_req) begin
            cnt = 0;
            imem_ack = 1'b0;
            imem_rdata = 32'hBAD0_BAD0;
        end else begin
            cnt++;
            if (cnt > ack_delay) begin
                imem_ack = 1'b1;
                imem_rdata = mem(imem_addr);
                cnt = 0;
            end else begin
                imem_ack = 1'b0;
                imem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (imem_req && (!prev_req || prev_ack)) begin
                if (exp_addr.size() == 0) chk("unexpected_req", imem_addr, 32'hFFFF_FFFF);
                else chk("req_addr", imem_addr, exp_addr.pop_front());
            end else if (imem_req) begin
                chk("addr_stable", imem_addr, prev_addr);
            end
            if (instr_valid && dec_ready) begin
                n_xfer++;
                if (exp_x.size() == 0) begin
                    chk("unexpected_xfer_pc", instr_pc, 32'hFFFF_FFFF);
                end else begin
                    xfer_t x;
                    x = exp_x.pop_front();
                    chk("xfer_instr", instr, x.instr);
                    chk("xfer_pc", instr_pc, x.pc);
                    chk("xfer_pc_inc", instr_pc_inc, x.inc);
                end
            end
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
        end
    end

    initial begin
        int n0;
        rst = 1'b1;
        dec_ready = 1'b1;
        redirect = 1'b0;
        redirect_target = '0;
        step();
        step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_pc_inc", instr_pc_inc, 32'h4);
        chk("rst_err", {31'd0, misalign_err}, 32'd0);

        // Zero-wait streaming: 0,4,8,C
        foreach (exp_addr[i]) exp_addr.delete(i);
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8); exp_addr.push_back(32'hC);
        exp_addr.push_back(32'h10);
        push_x(32'h0); push_x(32'h4); push_x(32'h8); push_x(32'hC);
        rst = 1'b0;
        run_until(4);

        // Stall in HOLD for 5 cycles
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_pc", instr_pc, 32'h10);
            chk("hold_noreq", {31'd0, imem_req}, 32'd0);
        end
        push_x(32'h10); push_x(32'h14);
        exp_addr.push_back(32'h14); exp_addr.push_back(32'h18);
        ack_delay = 3;
        dec_ready = 1'b1;
        run_until(6);

        // Request to 0x18 outstanding: redirect 0x100, then 0x200 during KILL
        exp_addr.push_back(32'h200);
        redirect = 1'b1; redirect_target = 32'h100;
        step();
        redirect_target = 32'h200;
        step();
        redirect = 1'b0;
        wait_valid();
        chk("kill_pc", instr_pc, 32'h200);

        // Redirect + dec_ready in HOLD, then ack+redirect into pc wrap
        n0 = n_xfer;
        push_x(32'h200); push_x(32'hFFFF_FFFC); push_x(32'h0);
        exp_addr.push_back(32'h300); exp_addr.push_back(32'hFFFF_FFFC);
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        dec_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h300;
        step();
        redirect = 1'b0;
        step();
        step();
        step();
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFC; ack_delay = 0;
        step();
        redirect = 1'b0;
        run_until(n0 + 3);

        // Misaligned redirect from HOLD 0x4
        wait_valid();
        if (!MIS) exp_addr.push_back(32'h100);
        redirect = 1'b1; redirect_target = 32'h102;
        step();
        redirect = 1'b0;
        step(); step(); step();
        chk("mis_err", {31'd0, misalign_err}, {31'd0, MIS});
        chk("mis_noreq", {31'd0, imem_req}, 32'd0);
        chk("mis_valid", {31'd0, instr_valid}, {31'd0, !MIS});
        chk("mis_pc", instr_pc, MIS ? 32'h4 : 32'h100);

        // Reset during an outstanding request
        if (!MIS) begin
            push_x(32'h100);
            exp_addr.push_back(32'h104);
        end
        ack_delay = 3;
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        chk("rst2_req", {31'd0, imem_req}, 32'd0);
        chk("rst2_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst2_pc_inc", instr_pc_inc, 32'h4);
        chk("rst2_err", {31'd0, misalign_err}, 32'd0);
        chk("rst2_addr", imem_addr, 32'h0);
        n0 = n_xfer;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        push_x(32'h0);
        ack_delay = 0;
        step();
        rst = 1'b0;
        #1;
        chk("first_req_idle", {31'd0, imem_req}, 32'd0);
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        dec_ready = 1'b1;
        run_until(n0 + 1);
        for (int i = 0; i < 5; i++) step();
        chk("addr_q_empty", exp_addr.size(), 32'd0);
        chk("xfer_q_empty", exp_x.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer sitting between the program-counter logic, instruction memory and decode. Owns the fetch PC, issues one instruction-memory request at a time over a req/ack handshake, and presents each returned instruction to decode with a valid/ready handshake. Applies branch/jump redirects from execute, including redirects that arrive while a memory request is in flight; stale responses are discarded.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  memory request; held high until imem_ack
- imem_addr  out  32  request address; stable while imem_req high
- imem_ack  in  1  single-cycle response strobe; may assert in the same cycle as imem_req
- imem_rdata  in  32  instruction word, valid only when imem_ack=1
- instr_valid  out  1  instruction available to decode
- instr  out  32  instruction word
- instr_pc  out  32  address of instr
- instr_pc_inc  out  32  instr_pc + 4, for link-register writes
- dec_ready  in  1  decode accepts instr this cycle
- redirect  in  1  single-cycle control-flow change from execute
- redirect_target  in  32  new fetch address when redirect=1
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State pc_q (next fetch address), redir_q (pending target), FSM: IDLE, FETCH, KILL, HOLD, HALT.
- IDLE: reset state; all outputs low; unconditionally -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc_q.
  - ack, no redirect: instr<=imem_rdata, instr_pc<=pc_q, pc_q<=pc_q+4 -> HOLD.
  - ack + redirect: data discarded, pc_q<=target -> FETCH (new request next cycle).
  - redirect, no ack: redir_q<=target -> KILL.
  - neither: stay.
- KILL: imem_req=1, imem_addr=pc_q (unchanged, request completes). redirect: redir_q<=target (latest wins). On ack: data discarded, pc_q<=redirect ? target : redir_q -> FETCH.
- HOLD: instr_valid=1; instr/instr_pc stable.
  - dec_ready, no redirect: transfer -> FETCH.
  - redirect (with or without dec_ready): pc_q<=target -> FETCH; a same-cycle dec_ready still counts as a completed transfer.
- Arithmetic: 32-bit, pc_q+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000; instr_pc_inc wraps likewise.
- redirect in IDLE or HALT ignored.
- instr_valid never asserts for a discarded response.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, instr_pc_inc=4, misalign_err=0; pc_q=RESET_PC, state IDLE. rst mid-request abandons it immediately; an ack arriving after reset is ignored (state IDLE).
- First imem_req: first cycle after IDLE, i.e. cycle 2 after rst falls.
- Fetch latency: instr_valid rises the cycle after imem_ack.
- Peak throughput with zero-wait memory and dec_ready=1: one instruction per 2 cycles.
- Redirect to first request at target: 1 cycle (FETCH/HOLD), or 1 cycle after the outstanding ack (KILL).
- All outputs registered or decoded from state; no combinational path from imem_ack/dec_ready/redirect to outputs.

## Configuration
- FETCH_CTRL_MISALIGN_EN defined: redirect accepted with redirect_target[1:0]!=0 sets misalign_err=1 and enters HALT (no requests, instr_valid=0) until rst; if a request is outstanding, KILL completes it first, then HALT.
- Undefined: redirect_target[1:0] forced to 2'b00, misalign_err tied 0, HALT unreachable.

## Test plan
- Reset, zero-wait ack, dec_ready=1: imem_addr sequence 0,4,8,C; instr_pc matches; instr_valid every other cycle.
- Ack delayed 3 cycles: imem_req and imem_addr=0 held stable 4 cycles; instr_valid once, instr=imem_rdata at ack.
- dec_ready=0 for 5 cycles in HOLD: instr/instr_pc stable, no imem_req; release -> next fetch at instr_pc+4.
- redirect to 0x100 while request to 0x8 outstanding, ack 2 cycles later: 0x8 data never valid; next imem_addr=0x100; second redirect to 0x200 during KILL -> next address 0x200.
- redirect + dec_ready in HOLD: transfer counted, next imem_addr = target; pc wrap from 0xFFFF_FFFC gives next 0x0.
- With FETCH_CTRL_MISALIGN_EN, redirect to 0x102: misalign_err=1 and imem_req stays 0 until rst; without macro, fetch proceeds at 0x100.
